// File: rtl/muldiv_hilo_unit.sv
// Multiply/divide engine owning HI/LO: radix-2 shift-add multiply, restoring divide.
// Latency 34 edges for mult/div (33 busy cycles), 1 edge for MTHI/MTLO and divide-by-zero; start while busy is ignored.
module muldiv_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             mf_req,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH);
   localparam int W2 = 2 * WIDTH;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
   localparam logic [W2-1:0]    ONE_2W   = W2'(1);

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             done_q, done_d;

   // Operand conditioning: magnitudes for signed ops, raw bits for unsigned ones.
   logic             op_signed;
   logic             sign_diff;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;

   assign op_signed = (op == OP_MULT) || (op == OP_DIV);
   assign sign_diff = op_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
   assign a_mag     = (op_signed && A[WIDTH-1]) ? (~A + ONE_W) : A;
   assign b_mag     = (op_signed && B[WIDTH-1]) ? (~B + ONE_W) : B;

   // Multiply step: acc holds {partial product, remaining multiplier bits}.
   logic [WIDTH:0]  mul_sum;
   logic [W2-1:0]   mul_next;

   assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Divide step: acc holds {partial remainder, dividend bits becoming quotient bits}.
   // The partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits
   // and a successful subtraction always fits back into WIDTH bits.
   logic [WIDTH:0]   div_part;
   logic             div_ge;
   logic [WIDTH-1:0] div_diff;
   logic [W2-1:0]    div_next;

   assign div_part = acc_q[W2-1:WIDTH-1];
   assign div_ge   = div_part >= {1'b0, opnd_q};
   assign div_diff = div_part[WIDTH-1:0] - opnd_q;
   assign div_next = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                            : {acc_q[W2-2:0], 1'b0};

   // Sign fix-up applied on the way into HI/LO.
   logic [W2-1:0]    prod_fix;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   assign prod_fix = neg_q  ? (~acc_q + ONE_2W) : acc_q;
   assign quot_fix = neg_q  ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
   assign rem_fix  = rneg_q ? (~acc_q[W2-1:WIDTH] + ONE_W) : acc_q[W2-1:WIDTH];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
                  OP_MULT, OP_MULTU: begin
                     acc_d    = {{WIDTH{1'b0}}, b_mag};
                     opnd_d   = a_mag;
                     neg_d    = sign_diff;
                     rneg_d   = 1'b0;
                     is_div_d = 1'b0;
                     cnt_d    = '0;
                     state_d  = S_RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     if (B == {WIDTH{1'b0}}) begin
                        hi_d   = A;
                        lo_d   = {WIDTH{1'b1}};
                        done_d = 1'b1;
                     end else begin
                        acc_d    = {{WIDTH{1'b0}}, a_mag};
                        opnd_d   = b_mag;
                        neg_d    = sign_diff;
                        rneg_d   = op_signed && A[WIDTH-1];
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = S_RUN;
                     end
                  end
                  default: ;
               endcase
            end
         end

         S_RUN: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end
         end

         S_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = quot_fix;
            end else begin
               hi_d = prod_fix[W2-1:WIDTH];
               lo_d = prod_fix[WIDTH-1:0];
            end
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         done_q   <= done_d;
      end
   end

   assign busy  = (state_q != S_IDLE);
   assign stall = busy & (mf_req | start);
   assign done  = done_q;
   assign HI    = hi_q;
   assign LO    = lo_q;

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Bench for muldiv_hilo_unit: directed test-plan cases plus randomized ops against a plain-arithmetic model.
module tb_muldiv_hilo_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        mf_req;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   int checks   = 0;
   int failures = 0;

   muldiv_hilo_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .A      (A),
      .B      (B),
      .mf_req (mf_req),
      .busy   (busy),
      .stall  (stall),
      .done   (done),
      .HI     (HI),
      .LO     (LO)
   );

   always #5 clk = ~clk;

   // Architectural result of one request, from signed/unsigned integer arithmetic.
   function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] hi, output logic [31:0] lo);
      longint      sp;
      logic [63:0] up;
      int          sa, sb, q, r;
      hi = 32'h0;
      lo = 32'h0;
      case (o)
         3'd0: begin
            sp = longint'($signed(a)) * longint'($signed(b));
            up = sp;
            hi = up[63:32];
            lo = up[31:0];
         end
         3'd1: begin
            up = {32'h0, a} * {32'h0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         3'd2: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               hi = 32'h0; lo = 32'h8000_0000;
            end else begin
               sa = a; sb = b;
               q = sa / sb; r = sa % sb;
               hi = r; lo = q;
            end
         end
         3'd3: begin
            if (b == 32'h0) begin
               hi = a; lo = 32'hFFFF_FFFF;
            end else begin
               hi = a % b; lo = a / b;
            end
         end
         default: ;
      endcase
   endfunction

   // Issues one request and waits (bounded) for done; lat counts edges until done is seen.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cnt);
      op = o; A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy === 1'b1) busy_cnt++;
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 3'd7; A = '0; B = '0; mf_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (HI !== 32'h0)  begin failures++; $display("FAIL reset_hi got=%h exp=0", HI); end
      checks++; if (LO !== 32'h0)  begin failures++; $display("FAIL reset_lo got=%h exp=0", LO); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
   endtask

   task automatic test_mult_directed;
      int lat, bc;
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
      checks++; if (lat !== 34) begin failures++; $display("FAIL multu_latency got=%0d exp=34", lat); end
      checks++; if (bc !== 33)  begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
      checks++; if (HI !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got=%h exp=fffffffe", HI); end
      checks++; if (LO !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got=%h exp=00000001", LO); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, lat, bc);
      checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_neg_hi got=%h exp=ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_neg_lo got=%h exp=ffffffeb", LO); end
      run_op(3'd0, 32'h8000_0000, 32'h8000_0000, lat, bc);
      checks++; if (HI !== 32'h4000_0000) begin failures++; $display("FAIL mult_min_hi got=%h exp=40000000", HI); end
      checks++; if (LO !== 32'h0) begin failures++; $display("FAIL mult_min_lo got=%h exp=0", LO); end
   endtask

   task automatic test_div_directed;
      int lat, bc;
      run_op(3'd2, 32'hFFFF_FFF9, 32'd2, lat, bc);
      checks++; if (lat !== 34) begin failures++; $display("FAIL div_latency got=%0d exp=34", lat); end
      checks++; if (LO !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_neg_lo got=%h exp=fffffffd", LO); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_neg_hi got=%h exp=ffffffff", HI); end
      run_op(3'd3, 32'd100, 32'd7, lat, bc);
      checks++; if (LO !== 32'd14) begin failures++; $display("FAIL divu_lo got=%h exp=0000000e", LO); end
      checks++; if (HI !== 32'd2)  begin failures++; $display("FAIL divu_hi got=%h exp=00000002", HI); end
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc);
      checks++; if (LO !== 32'h8000_0000) begin failures++; $display("FAIL div_ovf_lo got=%h exp=80000000", LO); end
      checks++; if (HI !== 32'h0) begin failures++; $display("FAIL div_ovf_hi got=%h exp=0", HI); end
   endtask

   task automatic test_div_zero;
      int lat, bc;
      run_op(3'd3, 32'h0000_1234, 32'h0, lat, bc);
      checks++; if (lat !== 1) begin failures++; $display("FAIL divz_latency got=%0d exp=1", lat); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL divz_busy got=%b exp=0", busy); end
      checks++; if (HI !== 32'h0000_1234) begin failures++; $display("FAIL divz_hi got=%h exp=00001234", HI); end
      checks++; if (LO !== 32'hFFFF_FFFF) begin failures++; $display("FAIL divz_lo got=%h exp=ffffffff", LO); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin
         failures++; $display("FAIL divz_after done=%b busy=%b exp=0/0", done, busy);
      end
   endtask

   task automatic test_mthi_during_run;
      int n;
      op = 3'd4; A = 32'hAAAA_5555; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      checks++; if (HI !== 32'hAAAA_5555) begin failures++; $display("FAIL mthi_hi got=%h exp=aaaa5555", HI); end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL mthi_flags busy=%b done=%b exp=0/0", busy, done);
      end
      op = 3'd1; A = 32'd3; B = 32'd5; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 mf_req = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL run_mf_stall got=%b exp=1", stall); end
      checks++; if (HI !== 32'hAAAA_5555) begin failures++; $display("FAIL run_hi_held got=%h exp=aaaa5555", HI); end
      mf_req = 1'b0;
      op = 3'd1; A = 32'd7; B = 32'd9; start = 1'b1;
      #1;
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL run_start_stall got=%b exp=1", stall); end
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      n = 0;
      while (done !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (done !== 1'b1) begin failures++; $display("FAIL run_done_timeout got=%b exp=1", done); end
      checks++; if (HI !== 32'h0)  begin failures++; $display("FAIL run_hi got=%h exp=0", HI); end
      checks++; if (LO !== 32'd15) begin failures++; $display("FAIL run_lo got=%h exp=0000000f", LO); end
      mf_req = 1'b1;
      #1;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_mf_stall got=%b exp=0", stall); end
      mf_req = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_busy got=%b exp=0", busy); end
   endtask

   task automatic test_reset_abort;
      int lat, bc, seen;
      op = 3'd1; A = $urandom; B = $urandom | 32'h1; start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      checks++; if (HI !== 32'h0 || LO !== 32'h0) begin
         failures++; $display("FAIL abort_hilo got=%h_%h exp=0_0", HI, LO);
      end
      seen = 0;
      repeat (40) begin
         if (done === 1'b1) seen++;
         @(posedge clk); #1;
      end
      checks++; if (seen !== 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", seen); end
      run_op(3'd1, 32'd2, 32'd3, lat, bc);
      checks++; if (LO !== 32'd6 || HI !== 32'h0) begin
         failures++; $display("FAIL abort_then_multu got=%h_%h exp=0_6", HI, LO);
      end
   endtask

   task automatic test_noop;
      logic [31:0] h, l;
      h = $urandom; l = $urandom;
      op = 3'd4; A = h; start = 1'b1;
      @(posedge clk); #1 op = 3'd5; A = l;
      @(posedge clk); #1 op = 3'd6; A = $urandom; B = 32'h0;
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL idle_start_stall got=%b exp=0", stall); end
      @(posedge clk); #1 op = 3'd7;
      @(posedge clk); #1 start = 1'b0;
      checks++; if (HI !== h || LO !== l) begin
         failures++; $display("FAIL noop_hilo got=%h_%h exp=%h_%h", HI, LO, h, l);
      end
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin
         failures++; $display("FAIL noop_flags busy=%b done=%b exp=0/0", busy, done);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bc;
      logic [31:0] eh, el;
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 4; i++) begin
         o = 3'(i);
         a = $urandom; b = $urandom;
         run_op(o, a, b, lat, bc);
         model(o, a, b, eh, el);
         checks++; if (lat !== 34 || HI !== eh || LO !== el) begin
            failures++;
            $display("FAIL back_to_back op=%0d lat=%0d got=%h_%h exp lat=34 %h_%h", o, lat, HI, LO, eh, el);
         end
      end
   endtask

   task automatic test_random;
      int lat, bc, elat;
      logic [31:0] eh, el, a, b;
      logic [2:0]  o;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom; b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'($urandom_range(1, 16));
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         run_op(o, a, b, lat, bc);
         model(o, a, b, eh, el);
         elat = (o[1] && b == 32'h0) ? 1 : 34;
         checks++; if (lat !== elat || HI !== eh || LO !== el) begin
            failures++;
            $display("FAIL random op=%0d a=%h b=%h lat=%0d got=%h_%h exp lat=%0d %h_%h",
                     o, a, b, lat, HI, LO, elat, eh, el);
         end
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin failures++; $display("FAIL random_done_pulse got=%b exp=0", done); end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_mult_directed();
      test_div_directed();
      test_div_zero();
      test_mthi_during_run();
      test_reset_abort();
      test_noop();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
